// File: rtl/la_rrarb_pkg.sv
// Shared sizing helpers for the round-robin arbiter and its picker.
package la_rrarb_pkg;

  // Width of a binary index into n entries; never below one bit.
  function automatic int idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the hold counter for a given hold limit; never below one bit.
  function automatic int cntw(input int maxhold);
    return (maxhold > 0) ? $clog2(maxhold + 1) : 1;
  endfunction

endpackage

// File: rtl/la_rrpick.sv
// Combinational rotate-priority picker: first set request scanning from ptr upward, mod N.
module la_rrpick
  import la_rrarb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idxw(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/la_rrarb.sv
// Round-robin arbiter with registered one-hot grant, zero-bubble handoff and optional
// hold-limit preemption of an owner that keeps others waiting.
module la_rrarb
  import la_rrarb_pkg::*;
#(
  parameter int    N       = 4,
  parameter int    MAXHOLD = 0,
  parameter string PROP    = "DEFAULT",
  localparam int   IW      = idxw(N)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          preempt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;
  localparam int         CW     = cntw(MAXHOLD);
  localparam logic [CW-1:0] CNT_TOP = CW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);

  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic          r_preempt;

  // PROP only steers the target library; it carries no function here.
  if (PROP != "") begin : g_prop
  end

  if (N == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (!nreset) r_gnt <= '0;
      else         r_gnt <= req & {N{en}};
    end
    assign r_gnt_id  = '0;
    assign r_preempt = 1'b0;
  end else begin : g_arb
    logic [0:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_own, w_rel, w_oth, w_hit, w_pre;
    logic [IW-1:0] w_nxt, w_pptr;
    logic [N-1:0]  w_preq, w_pk_oh;
    logic [IW-1:0] w_pk_idx;
    logic          w_pk_any;

    assign w_own  = (r_state == S_OWN);
    assign w_nxt  = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
    assign w_rel  = w_own & ~req[r_gnt_id];
    // The owner is masked out so a preempting pick can never re-select it.
    assign w_preq = req & ~r_gnt;
    assign w_oth  = |w_preq;
    assign w_pptr = w_own ? w_nxt : r_ptr;
    assign w_hit  = (MAXHOLD > 0) && (r_cnt == CNT_TOP);
    assign w_pre  = w_own & ~w_rel & en & w_oth & w_hit;

    la_rrpick #(.N(N), .IW(IW)) u_pick (
      .i_req    (w_preq),
      .i_ptr    (w_pptr),
      .o_onehot (w_pk_oh),
      .o_idx    (w_pk_idx),
      .o_any    (w_pk_any)
    );

    always_ff @(posedge clk) begin
      if (!nreset) begin
        r_state   <= S_IDLE;
        r_ptr     <= '0;
        r_cnt     <= '0;
        r_gnt     <= '0;
        r_gnt_id  <= '0;
        r_preempt <= 1'b0;
      end else begin
        r_preempt <= 1'b0;
        if (r_state == S_IDLE) begin
          if (en && w_pk_any) begin
            r_gnt    <= w_pk_oh;
            r_gnt_id <= w_pk_idx;
            r_cnt    <= '0;
            r_state  <= S_OWN;
          end
        end else if (w_rel) begin
          r_ptr <= w_nxt;
          if (en && w_pk_any) begin
            r_gnt    <= w_pk_oh;
            r_gnt_id <= w_pk_idx;
            r_cnt    <= '0;
          end else begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end else if (w_pre) begin
          r_ptr     <= w_nxt;
          r_gnt     <= w_pk_oh;
          r_gnt_id  <= w_pk_idx;
          r_cnt     <= '0;
          r_preempt <= 1'b1;
        end else if ((MAXHOLD > 0) && w_oth && !w_hit) begin
          // Saturates at the limit so a hold under en=0 cannot wrap.
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = |r_gnt;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_la_rrarb.sv
// Directed and constrained-random checks of la_rrarb (N=4, MAXHOLD=4).
module tb_la_rrarb;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy, preempt;

  int n_cmp = 0;
  int n_bad = 0;

  la_rrarb #(.N(N), .MAXHOLD(4), .PROP("DEFAULT")) u_dut (
    .clk     (clk),
    .nreset  (nreset),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant vector, owner index (when busy), busy and preempt in one go.
  task automatic chk_g(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic pre);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    if (g != 4'b0000) chk({tag, "_id"}, 32'(gnt_id), 32'(id));
    chk({tag, "_busy"}, 32'(busy), 32'(|g));
    chk({tag, "_pre"}, 32'(preempt), 32'(pre));
  endtask

  logic [N-1:0] prev_g, prev_r;
  int           wt [N];

  initial begin
    // Reset held with everything requesting.
    nreset = 1'b0; en = 1'b1; req = 4'b1111;
    tick(); chk_g("rst1", 4'b0000, 2'd0, 1'b0); chk("rst1_id", 32'(gnt_id), 0);
    tick(); chk_g("rst2", 4'b0000, 2'd0, 1'b0); chk("rst2_id", 32'(gnt_id), 0);
    nreset = 1'b1;
    tick(); chk_g("rst_rel", 4'b0001, 2'd0, 1'b0);

    // Rotation: each owner holds three sampled cycles then drops for one.
    for (int o = 0; o < 4; o++) begin
      tick(); chk_g("rot_hold_a", 4'(1 << o), 2'(o), 1'b0);
      tick(); chk_g("rot_hold_b", 4'(1 << o), 2'(o), 1'b0);
      req = 4'b1111 & ~4'(1 << o);
      tick(); chk_g("rot_next", 4'(1 << ((o + 1) % 4)), 2'((o + 1) % 4), 1'b0);
      req = 4'b1111;
    end

    // Wrap and skip.
    req = 4'b0000; tick(); chk_g("wr_idle0", 4'b0000, 2'd0, 1'b0);
    req = 4'b0100; tick(); chk_g("wr_g2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000; tick(); chk_g("wr_idle1", 4'b0000, 2'd0, 1'b0);
    req = 4'b0101; tick(); chk_g("wr_ptr3_g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0100; tick(); chk_g("wr_skip3_g2", 4'b0100, 2'd2, 1'b0);
    req = 4'b1000; tick(); chk_g("wr_g3", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000; tick(); chk_g("wr_idle2", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001; tick(); chk_g("wr_ptr0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000; tick(); chk_g("wr_g3b", 4'b1000, 2'd3, 1'b0);

    // Enable gating, also showing preemption is held off while en=0.
    req = 4'b0000; tick(); chk_g("en_idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0010; tick(); chk_g("en_g1", 4'b0010, 2'd1, 1'b0);
    en = 1'b0; req = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      tick(); chk_g("en_hold", 4'b0010, 2'd1, 1'b0);
    end
    req = 4'b0100;
    tick(); chk_g("en_rel", 4'b0000, 2'd0, 1'b0);
    tick(); chk_g("en_blk", 4'b0000, 2'd0, 1'b0);
    en = 1'b1;
    tick(); chk_g("en_on", 4'b0100, 2'd2, 1'b0);

    // Preemption after four contended cycles.
    req = 4'b0000; tick(); chk_g("pe_idle", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001; tick(); chk_g("pe_g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_g("pe_wait", 4'b0001, 2'd0, 1'b0);
    end
    tick(); chk_g("pe_fire", 4'b0100, 2'd2, 1'b1);
    tick(); chk_g("pe_after", 4'b0100, 2'd2, 1'b0);
    req = 4'b0001; tick(); chk_g("pe_back", 4'b0001, 2'd0, 1'b0);

    // Mid-grant reset clears grant and pointer.
    req = 4'b1000; tick(); chk_g("mr_g3", 4'b1000, 2'd3, 1'b0);
    nreset = 1'b0; tick(); chk_g("mr_rst", 4'b0000, 2'd0, 1'b0);
    chk("mr_id", 32'(gnt_id), 0);
    nreset = 1'b1; req = 4'b1001; tick(); chk_g("mr_ptr0", 4'b0001, 2'd0, 1'b0);

    // Random run: requests stay up until served, then drop at random.
    req = 4'b0000; en = 1'b1; tick();
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if (gnt[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b0;
        end
      end
      en = ($urandom_range(7) != 0);
      prev_g = gnt;
      prev_r = req;
      tick();
      chk("r_onehot", 32'($onehot0(gnt)), 1);
      chk("r_noreq", 32'(gnt & ~prev_r), 0);
      chk("r_busy", 32'(busy), 32'(|gnt));
      if (gnt != 4'b0000 && gnt != prev_g) begin
        for (int i = 0; i < N; i++) begin
          if (gnt[i] || !prev_r[i]) wt[i] = 0;
          else wt[i]++;
          chk("r_starve", 32'(wt[i] > N), 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
